// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings and default reset PC.
package fetch_sequencer_pkg;

  localparam int unsigned FETCH_ST_W = 1;

  typedef enum logic [FETCH_ST_W-1:0] {
    FETCH_ST_FETCH = 1'b0,
    FETCH_ST_HALT  = 1'b1
  } fetch_st_e;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0200;

  // Fetch addresses wrap FFFF -> 0000.
  function automatic logic [15:0] pc_next(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, hides the 1-cycle memory latency, halts and
// restarts on terminator dispatch/redirect. Optional FETCH_SKID_EN adds a skid register (else replay).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] addr_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic        wakeup,
  output logic        halted
);

  fetch_st_e   state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        inflight_v_q, inflight_v_d;
  logic [15:0] inflight_pc_q, inflight_pc_d;
  logic        wakeup_q;

  logic        fetch_st;
  logic        issue;
  logic        halt_go;

`ifdef FETCH_SKID_EN
  logic        skid_v_q, skid_v_d;
  logic [7:0]  skid_data_q, skid_data_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic        stall;
`endif

  always_comb begin
    fetch_st = (state_q == FETCH_ST_FETCH);

`ifdef FETCH_SKID_EN
    instr_valid = fetch_st & (skid_v_q | inflight_v_q);
    instr       = skid_v_q ? skid_data_q : din_i;
    instr_pc    = skid_v_q ? skid_pc_q : inflight_pc_q;
    stall       = inflight_v_q & ~instr_ready & ~skid_v_q;
    issue       = fetch_st &
                  ((~skid_v_q & ~(inflight_v_q & ~instr_ready)) |
                   (skid_v_q & instr_ready & ~inflight_v_q));
    addr_i      = pc_q;
`else
    instr_valid = fetch_st & inflight_v_q;
    instr       = din_i;
    instr_pc    = inflight_pc_q;
    // Refused byte: re-read the same address so memory re-delivers it next cycle.
    addr_i      = (inflight_v_q & ~instr_ready) ? inflight_pc_q : pc_q;
    issue       = fetch_st;
`endif

    halt_go = fetch_st & halt_req & instr_valid & instr_ready;
    halted  = (state_q == FETCH_ST_HALT);
    wakeup  = wakeup_q;

    state_d       = state_q;
    pc_d          = pc_q;
    inflight_v_d  = issue;
    inflight_pc_d = inflight_pc_q;

    if (issue) begin
      inflight_pc_d = addr_i;
      pc_d          = pc_next(addr_i);
    end

`ifdef FETCH_SKID_EN
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    if (fetch_st) begin
      if (skid_v_q && instr_ready) begin
        skid_v_d    = inflight_v_q;
        skid_data_d = din_i;
        skid_pc_d   = inflight_pc_q;
      end else if (stall) begin
        skid_v_d    = 1'b1;
        skid_data_d = din_i;
        skid_pc_d   = inflight_pc_q;
      end
    end
`endif

    // Terminator accepted: drop speculative bytes and freeze the PC.
    if (halt_go) begin
      state_d       = FETCH_ST_HALT;
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_v_d  = 1'b0;
`ifdef FETCH_SKID_EN
      skid_v_d      = 1'b0;
`endif
    end

    // Redirect takes priority over a simultaneous halt.
    if (redirect_valid) begin
      state_d      = FETCH_ST_FETCH;
      pc_d         = redirect_addr;
      inflight_v_d = 1'b0;
`ifdef FETCH_SKID_EN
      skid_v_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH_ST_FETCH;
      pc_q          <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= RESET_PC;
      wakeup_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      wakeup_q      <= redirect_valid;
    end
  end

`ifdef FETCH_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= 8'h00;
      skid_pc_q   <= RESET_PC;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run against a byte-stream model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr_i;
  logic [7:0]  din_i = 8'h00;
  logic [7:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        ready = 1'b1;
  logic        halt = 1'b0;
  logic        redir = 1'b0;
  logic [15:0] raddr = 16'h0000;
  logic        wakeup;
  logic        halted;

  int errs = 0;
  int checks = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .addr_i        (addr_i),
    .din_i         (din_i),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (ready),
    .halt_req      (halt),
    .redirect_valid(redir),
    .redirect_addr (raddr),
    .wakeup        (wakeup),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Synchronous memory whose content is the low address byte.
  always @(posedge clk) din_i <= addr_i[7:0];

  task automatic test_reset();
    rst = 1'b0; ready = 1'b1; halt = 1'b0; redir = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (addr_i !== 16'h0200) begin errs++; $display("FAIL reset_addr: got %h want 0200", addr_i); end
    checks++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (wakeup !== 1'b0) begin errs++; $display("FAIL reset_wakeup: got %b want 0", wakeup); end
    checks++; if (halted !== 1'b0) begin errs++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (instr_pc !== 16'h0200) begin errs++; $display("FAIL reset_pc: got %h want 0200", instr_pc); end
    rst = 1'b1;
  endtask

  // Stream from reset, 3-cycle stall at 0203, halt at 0207, redirect to 1234.
  task automatic test_stream_stall_halt();
    logic [15:0] exp;
    logic [15:0] hold_addr;
    exp = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== exp[7:0]) begin
        errs++; $display("FAIL stream: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         instr_valid, instr_pc, instr, exp, exp[7:0]);
      end
      if (i < 3) exp = exp + 16'd1;
    end
    ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0203 || instr !== 8'h03) begin
        errs++; $display("FAIL stall_hold: got v=%b pc=%h d=%h want v=1 pc=0203 d=03",
                         instr_valid, instr_pc, instr);
      end
      checks++; if (addr_i > 16'h0205) begin
        errs++; $display("FAIL stall_addr: got %h want <= 0205", addr_i);
      end
      if (j == 2) ready = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      exp = exp + 16'd1;
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== exp[7:0]) begin
        errs++; $display("FAIL stall_resume: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         instr_valid, instr_pc, instr, exp, exp[7:0]);
      end
    end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    hold_addr = addr_i;
    checks++; if (instr_valid !== 1'b0 || halted !== 1'b1) begin
      errs++; $display("FAIL halt_enter: got v=%b halted=%b want v=0 halted=1", instr_valid, halted);
    end
    repeat (2) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b0 || halted !== 1'b1 || addr_i !== hold_addr) begin
        errs++; $display("FAIL halt_hold: got v=%b halted=%b addr=%h want v=0 halted=1 addr=%h",
                         instr_valid, halted, addr_i, hold_addr);
      end
    end
    redir = 1'b1; raddr = 16'h1234;
    @(negedge clk);
    redir = 1'b0;
    checks++; if (wakeup !== 1'b1 || addr_i !== 16'h1234 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      errs++; $display("FAIL redirect_wake: got w=%b addr=%h v=%b h=%b want w=1 addr=1234 v=0 h=0",
                       wakeup, addr_i, instr_valid, halted);
    end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h1234 || instr !== 8'h34 || wakeup !== 1'b0) begin
      errs++; $display("FAIL redirect_byte: got v=%b pc=%h d=%h w=%b want v=1 pc=1234 d=34 w=0",
                       instr_valid, instr_pc, instr, wakeup);
    end
  endtask

  task automatic test_halt_redirect_same();
    halt = 1'b1; redir = 1'b1; raddr = 16'h4000; ready = 1'b1;
    @(negedge clk);
    halt = 1'b0; redir = 1'b0;
    checks++; if (halted !== 1'b0 || wakeup !== 1'b1 || addr_i !== 16'h4000) begin
      errs++; $display("FAIL halt_redir: got h=%b w=%b addr=%h want h=0 w=1 addr=4000",
                       halted, wakeup, addr_i);
    end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h4000 || instr !== 8'h00) begin
      errs++; $display("FAIL halt_redir_byte: got v=%b pc=%h d=%h want v=1 pc=4000 d=00",
                       instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    redir = 1'b1; raddr = 16'hFFFE; ready = 1'b1;
    @(negedge clk);
    redir = 1'b0;
    exp = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== exp[7:0]) begin
        errs++; $display("FAIL wrap: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         instr_valid, instr_pc, instr, exp, exp[7:0]);
      end
      if (i == 1) begin
        checks++; if (addr_i !== 16'h0000) begin
          errs++; $display("FAIL wrap_addr: got %h want 0000", addr_i);
        end
      end
      exp = exp + 16'd1;
    end
  endtask

  task automatic test_reset_mid_stall();
    redir = 1'b1; raddr = 16'h0300; ready = 1'b1;
    @(negedge clk);
    redir = 1'b0;
    @(negedge clk);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || addr_i !== 16'h0200 || instr_pc !== 16'h0200 ||
                  wakeup !== 1'b0 || halted !== 1'b0) begin
      errs++; $display("FAIL async_reset: got v=%b addr=%h pc=%h w=%b h=%b want 0/0200/0200/0/0",
                       instr_valid, addr_i, instr_pc, wakeup, halted);
    end
    @(negedge clk);
    rst = 1'b1; ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0200 + 16'(i) || instr !== 8'(i)) begin
        errs++; $display("FAIL after_reset: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         instr_valid, instr_pc, instr, 16'h0200 + 16'(i), 8'(i));
      end
    end
  endtask

  // Model: fetch is an ordered address stream from the last redirect; only squash may drop valid.
  task automatic test_random();
    logic        p_valid, p_ready, p_halt, p_redir, in_halt;
    logic [15:0] p_pc, p_raddr, exp_pc, halt_addr;
    logic [7:0]  p_instr;
    @(negedge clk);
    halt = 1'b0; ready = 1'b1; redir = 1'b1; raddr = 16'($urandom);
    p_redir = 1'b1; p_raddr = raddr; p_valid = 1'b0; p_ready = 1'b1; p_halt = 1'b0;
    p_pc = 16'h0; p_instr = 8'h0; in_halt = 1'b0; exp_pc = 16'h0; halt_addr = 16'h0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (p_redir) begin
        in_halt = 1'b0;
        exp_pc  = p_raddr;
        checks++; if (wakeup !== 1'b1 || halted !== 1'b0 || instr_valid !== 1'b0 || addr_i !== p_raddr) begin
          errs++; $display("FAIL rnd_redirect: got w=%b h=%b v=%b addr=%h want 1/0/0/%h",
                           wakeup, halted, instr_valid, addr_i, p_raddr);
        end
      end else if (p_halt) begin
        in_halt   = 1'b1;
        halt_addr = addr_i;
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || wakeup !== 1'b0) begin
          errs++; $display("FAIL rnd_halt: got h=%b v=%b w=%b want 1/0/0", halted, instr_valid, wakeup);
        end
      end else if (in_halt) begin
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || addr_i !== halt_addr || wakeup !== 1'b0) begin
          errs++; $display("FAIL rnd_halted: got h=%b v=%b addr=%h w=%b want 1/0/%h/0",
                           halted, instr_valid, addr_i, wakeup, halt_addr);
        end
      end else begin
        checks++; if (instr_valid !== 1'b1 || halted !== 1'b0 || wakeup !== 1'b0) begin
          errs++; $display("FAIL rnd_flow: got v=%b h=%b w=%b want 1/0/0", instr_valid, halted, wakeup);
        end
        if (p_valid && !p_ready) begin
          checks++; if (instr_pc !== p_pc || instr !== p_instr) begin
            errs++; $display("FAIL rnd_hold: got pc=%h d=%h want pc=%h d=%h", instr_pc, instr, p_pc, p_instr);
          end
        end
      end
      if (instr_valid === 1'b1) begin
        checks++; if (instr_pc !== exp_pc || instr !== exp_pc[7:0]) begin
          errs++; $display("FAIL rnd_order: got pc=%h d=%h want pc=%h d=%h",
                           instr_pc, instr, exp_pc, exp_pc[7:0]);
        end
      end
      p_valid = instr_valid; p_pc = instr_pc; p_instr = instr;
      ready   = ($urandom_range(0, 99) < 70);
      redir   = in_halt ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 4);
      raddr   = 16'($urandom);
      halt    = instr_valid & ready & ~in_halt & ($urandom_range(0, 99) < 6);
      if (instr_valid && ready) exp_pc = exp_pc + 16'd1;
      p_ready = ready; p_halt = halt; p_redir = redir; p_raddr = raddr;
    end
    @(negedge clk);
    halt = 1'b0; redir = 1'b0; ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream_stall_halt();
    test_halt_redirect_same();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
